// File: rtl/mem_port_arb_if.sv
// Memory-port arbiter bundle: CPU path, aux word-transfer path and the shared memory port.
// master = requesters plus memory (the environment); slave = the arbiter itself.
interface mem_port_arb_if;
  logic        cpu_req;
  logic [22:0] cpu_addr;
  logic        cpu_we_lo;
  logic        cpu_we_hi;
  logic [15:0] cpu_dati;
  logic [15:0] cpu_dato;
  logic        cpu_wait;

  logic        aux_req;
  logic [22:0] aux_addr;
  logic        aux_we;
  logic [15:0] aux_dati;
  logic [15:0] aux_dato;
  logic        aux_ack;

  logic [22:0] mem_addr;
  logic [15:0] mem_dati;
  logic        mem_oe;
  logic        mem_we_lo;
  logic        mem_we_hi;
  logic [15:0] mem_dato;

  modport master (
    output cpu_req, cpu_addr, cpu_we_lo, cpu_we_hi, cpu_dati,
    input  cpu_dato, cpu_wait,
    output aux_req, aux_addr, aux_we, aux_dati,
    input  aux_dato, aux_ack,
    input  mem_addr, mem_dati, mem_oe, mem_we_lo, mem_we_hi,
    output mem_dato
  );

  modport slave (
    input  cpu_req, cpu_addr, cpu_we_lo, cpu_we_hi, cpu_dati,
    output cpu_dato, cpu_wait,
    input  aux_req, aux_addr, aux_we, aux_dati,
    output aux_dato, aux_ack,
    output mem_addr, mem_dati, mem_oe, mem_we_lo, mem_we_hi,
    input  mem_dato
  );
endinterface

// File: rtl/mem_port_arb.sv
// Shares one memory port between the CPU (priority) and an aux requester with a fairness override.
// Each access holds registered strobes for MEM_LAT cycles; CPU is stalled via cpu_wait, aux holds aux_req until aux_ack.
module mem_port_arb #(
  parameter int MEM_LAT      = 4,
  parameter int AUX_WAIT_MAX = 32
) (
  input  logic          clk,
  input  logic          sys_rst_n,
  mem_port_arb_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CPU_ACC, CPU_HOLD, AUX_ACC, AUX_DONE} state_t;

  localparam logic [3:0] LAT_M1   = 4'(MEM_LAT - 1);
  localparam logic [7:0] WAIT_MAX = 8'(AUX_WAIT_MAX);

  state_t     st, st_nxt;
  logic [3:0] acc_cnt;
  logic [7:0] wait_ctr;
  logic       grant_cpu, grant_aux;
  logic       acc_last;

  assign acc_last = (acc_cnt == 4'd0);

  always_comb begin
    st_nxt    = st;
    grant_cpu = 1'b0;
    grant_aux = 1'b0;
    case (st)
      IDLE: begin
        // CPU keeps priority until a starved aux request crosses the fairness threshold
        if (bus.cpu_req && !(bus.aux_req && (wait_ctr >= WAIT_MAX))) begin
          grant_cpu = 1'b1;
          st_nxt    = CPU_ACC;
        end else if (bus.aux_req) begin
          grant_aux = 1'b1;
          st_nxt    = AUX_ACC;
        end
      end
      CPU_ACC:  if (acc_last) st_nxt = bus.cpu_req ? CPU_HOLD : IDLE;
      CPU_HOLD: if (!bus.cpu_req) st_nxt = IDLE;
      AUX_ACC:  if (acc_last) st_nxt = AUX_DONE;
      AUX_DONE: st_nxt = IDLE;
      default:  st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) st <= IDLE;
    else            st <= st_nxt;
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      acc_cnt       <= 4'd0;
      wait_ctr      <= 8'd0;
      bus.cpu_dato  <= 16'd0;
      bus.cpu_wait  <= 1'b0;
      bus.aux_dato  <= 16'd0;
      bus.aux_ack   <= 1'b0;
      bus.mem_addr  <= 23'd0;
      bus.mem_dati  <= 16'd0;
      bus.mem_oe    <= 1'b0;
      bus.mem_we_lo <= 1'b0;
      bus.mem_we_hi <= 1'b0;
    end else begin
      bus.aux_ack  <= 1'b0;
      bus.cpu_wait <= bus.cpu_req && (st != CPU_HOLD);

      if (grant_cpu) begin
        bus.mem_addr  <= bus.cpu_addr;
        bus.mem_dati  <= bus.cpu_dati;
        bus.mem_oe    <= !bus.cpu_we_lo && !bus.cpu_we_hi;
        bus.mem_we_lo <= bus.cpu_we_lo;
        bus.mem_we_hi <= bus.cpu_we_hi;
        acc_cnt       <= LAT_M1;
      end else if (grant_aux) begin
        bus.mem_addr  <= bus.aux_addr;
        bus.mem_dati  <= bus.aux_dati;
        bus.mem_oe    <= !bus.aux_we;
        bus.mem_we_lo <= bus.aux_we;
        bus.mem_we_hi <= bus.aux_we;
        acc_cnt       <= LAT_M1;
      end else if ((st == CPU_ACC) || (st == AUX_ACC)) begin
        if (acc_last) begin
          // mem_oe is still the registered read flag of this access
          if ((st == CPU_ACC) && bus.mem_oe) bus.cpu_dato <= bus.mem_dato;
          if (st == AUX_ACC) begin
            bus.aux_dato <= bus.mem_dato;
            bus.aux_ack  <= 1'b1;
          end
          bus.mem_oe    <= 1'b0;
          bus.mem_we_lo <= 1'b0;
          bus.mem_we_hi <= 1'b0;
        end else begin
          acc_cnt <= acc_cnt - 4'd1;
        end
      end

      if (!bus.aux_req || grant_aux)
        wait_ctr <= 8'd0;
      else if ((st != AUX_ACC) && (st != AUX_DONE) && (wait_ctr != 8'hFF))
        wait_ctr <= wait_ctr + 8'd1;
    end
  end

endmodule
